// File: rtl/fft_bin_serializer.sv
// Captures 16 parallel FFT bins into ping-pong frame buffers and streams them one bin per beat.
// Define FBS_MAG_EN to add the out_mag port (re^2 + im^2, aligned with out_re/out_im).
module fft_bin_serializer (
   input  logic               clk,
   input  logic               rst,
   input  logic               fft_valid,
   input  logic [31:0]        fft_d0,
   input  logic [31:0]        fft_d1,
   input  logic [31:0]        fft_d2,
   input  logic [31:0]        fft_d3,
   input  logic [31:0]        fft_d4,
   input  logic [31:0]        fft_d5,
   input  logic [31:0]        fft_d6,
   input  logic [31:0]        fft_d7,
   input  logic [31:0]        fft_d8,
   input  logic [31:0]        fft_d9,
   input  logic [31:0]        fft_d10,
   input  logic [31:0]        fft_d11,
   input  logic [31:0]        fft_d12,
   input  logic [31:0]        fft_d13,
   input  logic [31:0]        fft_d14,
   input  logic [31:0]        fft_d15,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [3:0]         out_idx,
   output logic signed [15:0] out_re,
   output logic signed [15:0] out_im,
   output logic               out_last,
`ifdef FBS_MAG_EN
   output logic [32:0]        out_mag,
`endif
   output logic               drop,
   output logic [7:0]         drop_cnt
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state;
   logic [1:0][15:0][31:0] bufm;
   logic [15:0][31:0]      din;
   logic [1:0]             full, full_nxt;
   logic                   wsel, rsel;
   logic                   hs, rel, cap, ld, ld_sel;
   logic [3:0]             ld_idx;
   logic [31:0]            ld_bin;

   assign din = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                 fft_d7, fft_d6, fft_d5, fft_d4, fft_d3, fft_d2, fft_d1, fft_d0};

   always_comb begin
      hs  = (state == SEND) && out_ready;
      rel = hs && (out_idx == 4'd15);
      // A buffer released by this cycle's last handshake may take the incoming frame.
      cap = fft_valid && (!full[wsel] || (rel && (rsel == wsel)));
      full_nxt = full;
      if (rel) full_nxt[rsel] = 1'b0;
      if (cap) full_nxt[wsel] = 1'b1;
      ld     = 1'b0;
      ld_sel = rsel;
      ld_idx = 4'd0;
      if (state == IDLE) begin
         ld = full[rsel];
      end else if (hs) begin
         if (out_idx != 4'd15) begin
            ld     = 1'b1;
            ld_idx = out_idx + 4'd1;
         end else begin
            ld_sel = ~rsel;
            ld     = full[~rsel];
         end
      end
      ld_bin = bufm[ld_sel][ld_idx];
   end

`ifdef FBS_MAG_EN
   logic signed [31:0] pre, pim;
   logic [32:0]        mag_nxt;
   always_comb begin
      pre     = $signed(ld_bin[31:16]) * $signed(ld_bin[31:16]);
      pim     = $signed(ld_bin[15:0]) * $signed(ld_bin[15:0]);
      mag_nxt = {1'b0, pre} + {1'b0, pim};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst && cap) bufm[wsel] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         full      <= 2'b00;
         wsel      <= 1'b0;
         rsel      <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= 4'd0;
         out_re    <= '0;
         out_im    <= '0;
         out_last  <= 1'b0;
`ifdef FBS_MAG_EN
         out_mag   <= '0;
`endif
         drop      <= 1'b0;
         drop_cnt  <= 8'd0;
      end else begin
         full <= full_nxt;
         if (cap) wsel <= ~wsel;
         if (rel) rsel <= ~rsel;
         drop <= fft_valid && !cap;
         if (fft_valid && !cap && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         if (ld) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_idx   <= ld_idx;
            out_re    <= ld_bin[31:16];
            out_im    <= ld_bin[15:0];
            out_last  <= (ld_idx == 4'd15);
`ifdef FBS_MAG_EN
            out_mag   <= mag_nxt;
`endif
         end else if (hs) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Directed bench for fft_bin_serializer: latency, backpressure, overflow, release/capture overlap, reset.
module tb_fft_bin_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fft_valid = 1'b0;
   logic [31:0] d [16];
   logic        out_ready = 1'b1;
   logic        out_valid, out_last, drop;
   logic [3:0]  out_idx;
   logic [15:0] out_re, out_im;
   logic [7:0]  drop_cnt;
`ifdef FBS_MAG_EN
   logic [32:0] out_mag;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fft_bin_serializer dut (
      .clk(clk), .rst(rst), .fft_valid(fft_valid),
      .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
      .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
      .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
      .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
      .out_ready(out_ready), .out_valid(out_valid), .out_idx(out_idx),
      .out_re(out_re), .out_im(out_im), .out_last(out_last),
`ifdef FBS_MAG_EN
      .out_mag(out_mag),
`endif
      .drop(drop), .drop_cnt(drop_cnt)
   );

   // Frame f, bin k: re = 16*f + k, im = -k
   function automatic logic [37:0] exp_beat(input int f, input int k);
      return {1'b1, 4'(k), 16'(f * 16 + k), 16'(-k), (k == 15)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_frame(input int f);
      for (int k = 0; k < 16; k++) d[k] = {16'(f * 16 + k), 16'(-k)};
   endtask

   task automatic test_reset();
      rst = 1'b0;
      fft_valid = 1'b1;
      set_frame(9);
      tick();
      tick();
      n_chk++;
      if ({out_valid, out_idx, out_re, out_im, out_last, drop, drop_cnt} !== 47'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%0b idx=%0d re=%h im=%h last=%0b drop=%0b cnt=%0d, want all 0",
                  out_valid, out_idx, out_re, out_im, out_last, drop, drop_cnt);
      end
`ifdef FBS_MAG_EN
      n_chk++;
      if (out_mag !== 33'd0) begin
         n_fail++;
         $display("FAIL reset_mag: got %h want 0", out_mag);
      end
`endif
      fft_valid = 1'b0;
      rst = 1'b1;
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ignores_fft_valid: out_valid=%0b want 0", out_valid);
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      set_frame(0);
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_latency_early: out_valid=%0b want 0", out_valid);
      end
      tick();
      for (int k = 0; k < 16; k++) begin
         n_chk++;
         if ({out_valid, out_idx, out_re, out_im, out_last} !== exp_beat(0, k)) begin
            n_fail++;
            $display("FAIL single_beat%0d: got %h want %h", k,
                     {out_valid, out_idx, out_re, out_im, out_last}, exp_beat(0, k));
         end
`ifdef FBS_MAG_EN
         n_chk++;
         if (out_mag !== 33'(2 * k * k)) begin
            n_fail++;
            $display("FAIL single_mag%0d: got %0d want %0d", k, out_mag, 2 * k * k);
         end
`endif
         tick();
      end
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle_after: out_valid=%0b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      int k = 0;
      out_ready = 1'b0;
      set_frame(1);
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      for (int c = 0; c < 100 && k < 16; c++) begin
         tick();
         if (out_valid) begin
            n_chk++;
            if ({out_valid, out_idx, out_re, out_im, out_last} !== exp_beat(1, k)) begin
               n_fail++;
               $display("FAIL bp_beat%0d: got %h want %h", k,
                        {out_valid, out_idx, out_re, out_im, out_last}, exp_beat(1, k));
            end
         end
         out_ready = ~out_ready;
         if (out_valid && out_ready) k++;
      end
      tick();
      n_chk++;
      if (k != 16 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_count: accepted=%0d out_valid=%0b want 16 and 0", k, out_valid);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_overflow();
      int drops = 0;
      int beats = 0;
      out_ready = 1'b0;
      for (int f = 1; f <= 3; f++) begin
         set_frame(f);
         fft_valid = 1'b1;
         tick();
         fft_valid = 1'b0;
         drops += int'(drop);
         tick();
         drops += int'(drop);
      end
      n_chk++;
      if (drops != 1 || drop_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL ovf_drop: pulses=%0d cnt=%0d want 1 and 1", drops, drop_cnt);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (out_valid) begin
            n_chk++;
            if ({out_valid, out_idx, out_re, out_im, out_last} !== exp_beat(1 + beats / 16, beats % 16)) begin
               n_fail++;
               $display("FAIL ovf_beat%0d: got %h want %h", beats,
                        {out_valid, out_idx, out_re, out_im, out_last}, exp_beat(1 + beats / 16, beats % 16));
            end
            beats++;
         end
         tick();
      end
      n_chk++;
      if (beats != 32 || drop_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL ovf_total: beats=%0d cnt=%0d want 32 and 1", beats, drop_cnt);
      end
   endtask

   task automatic test_simultaneous();
      int drops = 0;
      out_ready = 1'b0;
      for (int f = 4; f <= 5; f++) begin
         set_frame(f);
         fft_valid = 1'b1;
         tick();
         fft_valid = 1'b0;
         tick();
      end
      tick();
      out_ready = 1'b1;
      for (int b = 0; b < 48; b++) begin
         n_chk++;
         if ({out_valid, out_idx, out_re, out_im, out_last} !== exp_beat(4 + b / 16, b % 16)) begin
            n_fail++;
            $display("FAIL sim_beat%0d: got %h want %h", b,
                     {out_valid, out_idx, out_re, out_im, out_last}, exp_beat(4 + b / 16, b % 16));
         end
         if (b == 15) begin
            set_frame(6);
            fft_valid = 1'b1;
         end
         tick();
         fft_valid = 1'b0;
         drops += int'(drop);
      end
      n_chk++;
      if (drops != 0 || drop_cnt !== 8'd1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL sim_nodrop: pulses=%0d cnt=%0d v=%0b want 0, 1, 0", drops, drop_cnt, out_valid);
      end
   endtask

   task automatic test_extreme();
      for (int k = 0; k < 16; k++) d[k] = 32'h8000_8000;
      out_ready = 1'b1;
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      tick();
      for (int k = 0; k < 16; k++) begin
         n_chk++;
         if ({out_valid, out_idx, out_re, out_im} !== {1'b1, 4'(k), 32'h8000_8000}) begin
            n_fail++;
            $display("FAIL ext_beat%0d: v=%0b idx=%0d re=%h im=%h want 1 %0d 8000 8000",
                     k, out_valid, out_idx, out_re, out_im, k);
         end
`ifdef FBS_MAG_EN
         n_chk++;
         if (out_mag !== 33'h0_8000_0000) begin
            n_fail++;
            $display("FAIL ext_mag%0d: got %h want 080000000", k, out_mag);
         end
`endif
         tick();
      end
   endtask

   task automatic test_midreset();
      bit seen = 0;
      out_ready = 1'b1;
      set_frame(7);
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         tick();
         if (out_valid && out_idx == 4'd7) seen = 1;
      end
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL mrst_reach_bin7: bin 7 never presented within budget");
      end
      rst = 1'b0;
      set_frame(8);
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      n_chk++;
      if ({out_valid, out_idx, out_re, out_im, out_last, drop, drop_cnt} !== 47'd0) begin
         n_fail++;
         $display("FAIL mrst_outputs: got v=%0b idx=%0d re=%h im=%h last=%0b drop=%0b cnt=%0d, want all 0",
                  out_valid, out_idx, out_re, out_im, out_last, drop, drop_cnt);
      end
`ifdef FBS_MAG_EN
      n_chk++;
      if (out_mag !== 33'd0) begin
         n_fail++;
         $display("FAIL mrst_mag: got %h want 0", out_mag);
      end
`endif
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_chk++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mrst_quiet%0d: out_valid=%0b want 0", c, out_valid);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 16; k++) d[k] = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_simultaneous();
      test_extreme();
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
